dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port, the other end of the load/store interface driven from the MEM stage.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs byte-lane steering for stores and load formatting (sign- or zero-extended byte, halfword, word) from funct3.
- Returns read data or a write acknowledge over a valid/ready response channel.
- Replaces the single-cycle data memory when multi-cycle memory timing is modelled.

Parameters:
- XLEN, 32, data and address width.
- DEPTH_WORDS, 1024, number of 32-bit words in the backing array; word index is addr[11:2] at the default.
- LATENCY, 2, wait-state cycles between request acceptance and response (0..15 legal).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data, unshifted (the byte or halfword sits in the low lanes).
- req_we  input  4  store byte strobe, unshifted (0001 SB, 0011 SH, 1111 SW); 0000 means read.
- req_funct3  input  3  RISC-V load/store funct3.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  XLEN  formatted load data; 0 for writes and errors.
- rsp_err  output  1  misaligned or out-of-range access.

Behaviour:
- Reset values:
  - state IDLE.
  - req_ready=1 in the first cycle after reset.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Wait counter 0.
  - Backing array is not cleared by reset.
- req_ready is 1 only in IDLE; it is decoded from the state register.
- States:
  - IDLE: on req_valid&&req_ready, register addr, wdata, we, funct3; load counter with LATENCY; go to WAIT.
  - WAIT: decrement counter each cycle. When the counter is 0, commit the write or sample the read at that edge, load the rsp_* registers, and go to RESP. With LATENCY=0, WAIT lasts exactly one cycle.
  - RESP: hold rsp_valid=1 and keep rsp_rdata/rsp_err stable until rsp_ready=1. On the handshake edge: rsp_valid←0, rsp_rdata←0, rsp_err←0, go to IDLE.
- Latency: request accepted at edge T, rsp_valid first high after edge T+LATENCY+1.
- Throughput: at most one request per LATENCY+3 cycles.
- A req_valid arriving in the same cycle as the rsp handshake is not accepted; it is taken the next cycle in IDLE.
- Error checks (on registered request):
  - halfword access (funct3[1:0]=01) with addr[0]=1 → err.
  - word access (funct3[1:0]=10) with addr[1:0]≠00 → err.
  - funct3[1:0]=11 → err.
  - word index ≥ DEPTH_WORDS → err.
  - On err: no array write, rsp_rdata=0, rsp_err=1.
- Stores:
  - Lane strobe = req_we << addr[1:0].
  - Write data = req_wdata << (8*addr[1:0]).
  - Only strobed bytes of the addressed word change.
- Loads (word read, then lane select):
  - LB: byte at lane addr[1:0], sign-extended. LBU: same byte, zero-extended.
  - LH: halfword at addr[1] (bytes 1:0 or 3:2), sign-extended. LHU: same halfword, zero-extended.
  - LW: full word.
  - A write commits before a later read, so the read returns the new data.
- Reset mid-operation (WAIT or RESP): transaction dropped, no response. A write not yet committed (still in WAIT) never reaches the array. A write already committed (in RESP) stays.
- Request inputs are ignored outside IDLE; changing them after acceptance has no effect.

Test Plan:
- LATENCY=2. SW addr 0x10, wdata 0xDEADBEEF, we 1111, accepted at cycle 5 → rsp_valid at cycle 8, err=0, rdata=0. Then LW 0x10 → rdata 0xDEADBEEF.
- After the above, SB addr 0x11, wdata 0x000000AA, we 0001 → word 0xDEADAAEF. LB 0x11 → 0xFFFFFFAA. LBU 0x11 → 0x000000AA. LH 0x12 → 0xFFFFDEAD. LHU 0x10 → 0x0000AAEF.
- Back-pressure: hold rsp_ready=0 for 4 cycles in RESP → rsp_valid, rdata, err stable and req_ready=0 throughout. rsp_ready=1 → next cycle rsp_valid=0, req_ready=1.
- Misaligned LW 0x13 → err=1, rdata=0. SH 0x21 with wdata 0x1234 → err=1, and a later LW 0x20 returns the prior value unchanged. Index ≥ DEPTH_WORDS → err=1.
- Reset asserted one cycle after accepting SW 0x30=0x55 (in WAIT) → no rsp_valid, req_ready=1 after reset, LW 0x30 returns the old value.
- LATENCY=0 build: LW accepted at edge T → rsp_valid after edge T+1. Back-to-back requests accepted every 3 cycles with rsp_ready tied high.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the pipeline's data-memory port. Accepts one
// load/store request at a time, waits LATENCY cycles, then commits the store
// or samples and formats the load, and returns the result on a valid/ready
// response channel. Used in place of the single-cycle data memory when
// multi-cycle memory timing is modelled.
//
// Parameters
//   XLEN         data / address width
//   DEPTH_WORDS  number of 32-bit words in the backing array
//   LATENCY      wait-state cycles between acceptance and response (0..15)
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   req_valid    request present
//   req_ready    responder can accept a request (high only in IDLE)
//   req_addr     byte address
//   req_wdata    store data, unshifted (byte/halfword in the low lanes)
//   req_we       store byte strobe, unshifted; 0000 means read
//   req_funct3   RISC-V load/store funct3
//   rsp_valid    response present
//   rsp_ready    consumer accepts the response
//   rsp_rdata    formatted load data; 0 for writes and errors
//   rsp_err      misaligned or out-of-range access
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [3:0]      req_we,
  input  logic [2:0]      req_funct3,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int              IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [XLEN-3:0] DEPTH_LIM = (XLEN-2)'(DEPTH_WORDS);
  localparam logic [3:0]      LAT_INIT  = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic [3:0]      cnt_q,       cnt_d;
  logic [XLEN-1:0] addr_q,      addr_d;
  logic [31:0]     wdata_q,     wdata_d;
  logic [3:0]      we_q,        we_d;
  logic [2:0]      funct3_q,    funct3_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q,   rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Decode of the registered request
  // ---------------------------------------------------------------------------
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic             misaligned;
  logic             out_of_range;
  logic             acc_err;
  logic             is_write;
  logic             commit;
  logic             mem_we;
  logic [3:0]       wstrb;
  logic [31:0]      wdata_sh;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [XLEN-1:0]  load_data;

  assign lane = addr_q[1:0];
  assign idx  = addr_q[IDX_W+1:2];

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a value on
    // every path (here via the default arm); a missing one infers a latch.
    case (funct3_q[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign out_of_range = (addr_q[XLEN-1:2] >= DEPTH_LIM);
  assign acc_err      = misaligned | out_of_range;
  assign is_write     = |we_q;

  // The commit/sample edge is the last WAIT cycle. A reset on that same edge
  // must still keep an uncommitted store out of the array.
  assign commit = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_we = commit && is_write && !acc_err && !reset;

  // Store steering: strobe and data move up to the addressed byte lane.
  assign wstrb    = req_we_shift(we_q, lane);
  assign wdata_sh = wdata_q << {lane, 3'b000};

  function automatic logic [3:0] req_we_shift(input logic [3:0] we, input logic [1:0] sh);
    return we << sh;
  endfunction

  // Load formatting: read the whole word, then pick and extend the lane.
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = rd_word[16*lane[1] +: 16];

  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{(XLEN-16){rd_half[15]}}, rd_half};
      3'b100:  load_data = XLEN'(rd_byte);
      3'b101:  load_data = XLEN'(rd_half);
      default: load_data = XLEN'(rd_word);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Backing array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; clearing it would need a per-word reset
  // network and its contents are meant to survive a reset of the control path.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        // req_ready is high throughout IDLE, so req_valid alone is the handshake.
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata[31:0];
          we_d     = req_we;
          funct3_d = req_funct3;
          cnt_d    = LAT_INIT;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || is_write) ? '0 : load_data;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM: state and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= '0;
      funct3_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. One instance is built with LATENCY=2 and
// carries the functional tests; a second with LATENCY=0 checks minimum latency
// and back-to-back throughput. Inputs change half a cycle away from the
// sampling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [2:0]  f3;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_we;
  logic [2:0]  req_funct3;

  logic        req_valid_0, req_ready_0, rsp_valid_0, rsp_ready_0, rsp_err_0;
  logic [31:0] req_addr_0, req_wdata_0, rsp_rdata_0;
  logic [3:0]  req_we_0;
  logic [2:0]  req_funct3_0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_0), .req_ready(req_ready_0), .req_addr(req_addr_0),
    .req_wdata(req_wdata_0), .req_we(req_we_0), .req_funct3(req_funct3_0),
    .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready_0), .rsp_rdata(rsp_rdata_0),
    .rsp_err(rsp_err_0)
  );

  // Drive one request into the LATENCY=2 instance. Returns the number of
  // rising edges from acceptance to the first rsp_valid, plus the response.
  // With ack=1 the response handshake is completed before returning; with
  // ack=0 the task returns at the falling edge where rsp_valid was first seen.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] we, input logic [2:0] f3, input bit ack,
                       output int lat, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = a;
    req_wdata  = wd;
    req_we     = we;
    req_funct3 = f3;
    rsp_ready  = ack;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    // Scramble the request bus after acceptance; the DUT must ignore it.
    req_valid  = 1'b0;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'hFFFF_FFFF;
    req_we     = 4'hF;
    req_funct3 = 3'b111;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!rsp_valid && lat < 40);
    rd = rsp_rdata;
    er = rsp_err;
    if (ack) @(posedge clk);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_we      = '0;
    req_funct3  = '0;
    rsp_ready   = 1'b1;
    req_valid_0 = 1'b0;
    req_addr_0  = '0;
    req_wdata_0 = '0;
    req_we_0    = '0;
    req_funct3_0 = '0;
    rsp_ready_0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset req_ready got %b want 1", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset rsp_valid got %b want 0", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset rsp_rdata got %h want 0", rsp_rdata); end
    n_vec++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset rsp_err got %b want 0", rsp_err); end
    n_vec++; if (req_ready_0 !== 1'b1) begin n_bad++; $display("FAIL reset0 req_ready got %b want 1", req_ready_0); end
    n_vec++; if (rsp_valid_0 !== 1'b0) begin n_bad++; $display("FAIL reset0 rsp_valid got %b want 0", rsp_valid_0); end
  endtask

  task automatic test_store_load();
    vec_t tv [2];
    int lat; logic [31:0] rd; logic er;
    tv = '{
      '{32'h10, 32'hDEADBEEF, 4'hF, 3'b010, 32'h0,        1'b0},  // SW
      '{32'h10, 32'h0,        4'h0, 3'b010, 32'hDEADBEEF, 1'b0}   // LW
    };
    for (int i = 0; i < 2; i++) begin
      issue(tv[i].addr, tv[i].wdata, tv[i].we, tv[i].f3, 1'b1, lat, rd, er);
      n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL store_load[%0d] latency got %0d want 3", i, lat); end
      n_vec++; if (rd !== tv[i].rd) begin n_bad++; $display("FAIL store_load[%0d] rdata got %h want %h", i, rd, tv[i].rd); end
      n_vec++; if (er !== tv[i].err) begin n_bad++; $display("FAIL store_load[%0d] err got %b want %b", i, er, tv[i].err); end
    end
  endtask

  task automatic test_byte_half();
    vec_t tv [12];
    int lat; logic [31:0] rd; logic er;
    tv = '{
      '{32'h11, 32'h000000AA, 4'h1, 3'b000, 32'h0,        1'b0},  // SB lane 1
      '{32'h10, 32'h0,        4'h0, 3'b010, 32'hDEADAAEF, 1'b0},  // LW
      '{32'h11, 32'h0,        4'h0, 3'b000, 32'hFFFFFFAA, 1'b0},  // LB
      '{32'h11, 32'h0,        4'h0, 3'b100, 32'h000000AA, 1'b0},  // LBU
      '{32'h12, 32'h0,        4'h0, 3'b001, 32'hFFFFDEAD, 1'b0},  // LH upper
      '{32'h10, 32'h0,        4'h0, 3'b101, 32'h0000AAEF, 1'b0},  // LHU lower
      '{32'h12, 32'h00005678, 4'h3, 3'b001, 32'h0,        1'b0},  // SH upper
      '{32'h10, 32'h0,        4'h0, 3'b010, 32'h5678AAEF, 1'b0},  // LW
      '{32'h12, 32'h0,        4'h0, 3'b001, 32'h00005678, 1'b0},  // LH positive
      '{32'h13, 32'h00000080, 4'h1, 3'b000, 32'h0,        1'b0},  // SB lane 3
      '{32'h13, 32'h0,        4'h0, 3'b000, 32'hFFFFFF80, 1'b0},  // LB lane 3
      '{32'h10, 32'h0,        4'h0, 3'b010, 32'h8078AAEF, 1'b0}   // LW
    };
    for (int i = 0; i < 12; i++) begin
      issue(tv[i].addr, tv[i].wdata, tv[i].we, tv[i].f3, 1'b1, lat, rd, er);
      n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL byte_half[%0d] latency got %0d want 3", i, lat); end
      n_vec++; if (rd !== tv[i].rd) begin n_bad++; $display("FAIL byte_half[%0d] rdata got %h want %h", i, rd, tv[i].rd); end
      n_vec++; if (er !== tv[i].err) begin n_bad++; $display("FAIL byte_half[%0d] err got %b want %b", i, er, tv[i].err); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er;
    issue(32'h10, 32'h0, 4'h0, 3'b010, 1'b0, lat, rd, er);
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL bp latency got %0d want 3", lat); end
    n_vec++; if (rd !== 32'h8078AAEF) begin n_bad++; $display("FAIL bp rdata got %h want 8078aaef", rd); end
    // A new request waits on the bus while the response is stalled.
    req_valid  = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    req_we     = 4'h0;
    req_funct3 = 3'b010;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold[%0d] rsp_valid got %b want 1", i, rsp_valid); end
      n_vec++; if (rsp_rdata !== 32'h8078AAEF) begin n_bad++; $display("FAIL bp_hold[%0d] rdata got %h want 8078aaef", i, rsp_rdata); end
      n_vec++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL bp_hold[%0d] err got %b want 0", i, rsp_err); end
      n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold[%0d] req_ready got %b want 0", i, req_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk);  // response handshake; the pending request is not taken here
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release rsp_valid got %b want 0", rsp_valid); end
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release req_ready got %b want 1", req_ready); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL bp_release rdata got %h want 0", rsp_rdata); end
    @(posedge clk);  // pending request accepted in IDLE
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!rsp_valid && lat < 40);
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL bp_next latency got %0d want 3", lat); end
    n_vec++; if (rsp_rdata !== 32'h8078AAEF) begin n_bad++; $display("FAIL bp_next rdata got %h want 8078aaef", rsp_rdata); end
    @(posedge clk);
  endtask

  task automatic test_errors();
    vec_t tv [11];
    int lat; logic [31:0] rd; logic er;
    tv = '{
      '{32'h13,   32'h0,        4'h0, 3'b010, 32'h0,        1'b1},  // misaligned LW
      '{32'h20,   32'hCAFEF00D, 4'hF, 3'b010, 32'h0,        1'b0},  // SW
      '{32'h21,   32'h00001234, 4'h3, 3'b001, 32'h0,        1'b1},  // misaligned SH
      '{32'h20,   32'h0,        4'h0, 3'b010, 32'hCAFEF00D, 1'b0},  // unchanged
      '{32'h1000, 32'h0,        4'h0, 3'b010, 32'h0,        1'b1},  // index 1024
      '{32'h1010, 32'h11111111, 4'hF, 3'b010, 32'h0,        1'b1},  // OOR store
      '{32'h10,   32'h0,        4'h0, 3'b010, 32'h8078AAEF, 1'b0},  // no aliasing
      '{32'h20,   32'h0,        4'h0, 3'b011, 32'h0,        1'b1},  // funct3 x11
      '{32'h23,   32'h0,        4'h0, 3'b001, 32'h0,        1'b1},  // LH odd
      '{32'h22,   32'h0,        4'h0, 3'b001, 32'hFFFFCAFE, 1'b0},  // LH ok
      '{32'h23,   32'h0,        4'h0, 3'b100, 32'h000000CA, 1'b0}   // LBU lane 3
    };
    for (int i = 0; i < 11; i++) begin
      issue(tv[i].addr, tv[i].wdata, tv[i].we, tv[i].f3, 1'b1, lat, rd, er);
      n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL errors[%0d] latency got %0d want 3", i, lat); end
      n_vec++; if (rd !== tv[i].rd) begin n_bad++; $display("FAIL errors[%0d] rdata got %h want %h", i, rd, tv[i].rd); end
      n_vec++; if (er !== tv[i].err) begin n_bad++; $display("FAIL errors[%0d] err got %b want %b", i, er, tv[i].err); end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er;
    issue(32'h30, 32'h0BADC0DE, 4'hF, 3'b010, 1'b1, lat, rd, er);
    n_vec++; if (er !== 1'b0) begin n_bad++; $display("FAIL rmid_init err got %b want 0", er); end
    // Store accepted, then reset while it is still waiting.
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 32'h30;
    req_wdata  = 32'h00000055;
    req_we     = 4'hF;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_wait req_ready got %b want 0", req_ready); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_drop[%0d] rsp_valid got %b want 0", i, rsp_valid); end
      n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_drop[%0d] req_ready got %b want 1", i, req_ready); end
    end
    issue(32'h30, 32'h0, 4'h0, 3'b010, 1'b1, lat, rd, er);
    n_vec++; if (rd !== 32'h0BADC0DE) begin n_bad++; $display("FAIL rmid_old rdata got %h want 0badc0de", rd); end
    // Store already committed (response stalled) survives a reset.
    issue(32'h34, 32'h00000077, 4'hF, 3'b010, 1'b0, lat, rd, er);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rresp rsp_valid got %b want 0", rsp_valid); end
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rresp req_ready got %b want 1", req_ready); end
    issue(32'h34, 32'h0, 4'h0, 3'b010, 1'b1, lat, rd, er);
    n_vec++; if (rd !== 32'h00000077) begin n_bad++; $display("FAIL rresp_kept rdata got %h want 00000077", rd); end
  endtask

  task automatic test_lat0();
    bit exp_rdy, exp_rv;
    @(negedge clk);
    req_valid_0  = 1'b1;
    req_addr_0   = 32'h40;
    req_wdata_0  = 32'h01020304;
    req_we_0     = 4'hF;
    req_funct3_0 = 3'b010;
    rsp_ready_0  = 1'b1;
    // Continuous stores: accept, wait, respond, repeat every 3 cycles.
    for (int c = 0; c < 12; c++) begin
      exp_rdy = (c % 3 == 0);
      exp_rv  = (c % 3 == 2);
      n_vec++; if (req_ready_0 !== exp_rdy) begin n_bad++; $display("FAIL lat0_b2b[%0d] req_ready got %b want %b", c, req_ready_0, exp_rdy); end
      n_vec++; if (rsp_valid_0 !== exp_rv) begin n_bad++; $display("FAIL lat0_b2b[%0d] rsp_valid got %b want %b", c, rsp_valid_0, exp_rv); end
      if (exp_rv) begin
        n_vec++; if (rsp_rdata_0 !== 32'h0) begin n_bad++; $display("FAIL lat0_b2b[%0d] rdata got %h want 0", c, rsp_rdata_0); end
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_we_0 = 4'h0;  // now a load of the same word
    @(posedge clk);
    #1 req_valid_0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (rsp_valid_0 !== 1'b1) begin n_bad++; $display("FAIL lat0_lw rsp_valid got %b want 1", rsp_valid_0); end
    n_vec++; if (rsp_rdata_0 !== 32'h01020304) begin n_bad++; $display("FAIL lat0_lw rdata got %h want 01020304", rsp_rdata_0); end
    n_vec++; if (rsp_err_0 !== 1'b0) begin n_bad++; $display("FAIL lat0_lw err got %b want 0", rsp_err_0); end
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (rsp_valid_0 !== 1'b0) begin n_bad++; $display("FAIL lat0_done rsp_valid got %b want 0", rsp_valid_0); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_half();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_lat0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
